// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that shares one UART byte transmitter
// between NREQ requesters, with an owner-idle watchdog that forces release.
module uart_tx_arbiter #(
  parameter int NREQ    = 2,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1024,
  localparam int OW     = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  output logic                     tx_valid,
  output logic [DATA_W-1:0]        tx_data,
  input  logic                     tx_ready,
  output logic [OW-1:0]            owner,
  output logic                     locked,
  output logic                     timeout_evt,
  output logic [15:0]              byte_cnt
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic            locked_q, locked_d;
  logic            timeout_evt_q, timeout_evt_d;
  logic [15:0]     byte_cnt_q, byte_cnt_d;
  logic [CW-1:0]   idle_cnt_q, idle_cnt_d;

  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              grant_found;
  logic [OW-1:0]     grant_idx;
  logic              handshake;

  // Current owner's request lines.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == OW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // First valid requester scanning owner+1, owner+2, ... so the last owner goes last.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = owner_q;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(owner_q) + k) % NREQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = OW'(idx);
      end
    end
  end

  always_comb begin
    tx_valid  = (state_q == LOCKED) && sel_valid;
    tx_data   = tx_valid ? sel_data : '0;
    handshake = tx_valid && tx_ready;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (state_q == LOCKED) && (owner_q == OW'(i)) && tx_ready;
    end
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    locked_d      = locked_q;
    timeout_evt_d = 1'b0;
    byte_cnt_d    = byte_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          owner_d    = grant_idx;
          locked_d   = 1'b1;
          idle_cnt_d = '0;
          state_d    = LOCKED;
        end
      end
      LOCKED: begin
        if (handshake) begin
          byte_cnt_d = byte_cnt_q + 16'd1;
          idle_cnt_d = '0;
          if (sel_last) begin
            state_d  = IDLE;
            locked_d = 1'b0;
          end
        end else if (!sel_valid) begin
          // Back-pressure (valid held, tx_ready low) deliberately leaves the counter alone.
          if (idle_cnt_q == CW'(TIMEOUT - 1)) begin
            state_d       = IDLE;
            locked_d      = 1'b0;
            timeout_evt_d = 1'b1;
            idle_cnt_d    = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d  = IDLE;
        locked_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      owner_q       <= OW'(NREQ - 1);
      locked_q      <= 1'b0;
      timeout_evt_q <= 1'b0;
      byte_cnt_q    <= '0;
      idle_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      locked_q      <= locked_d;
      timeout_evt_q <= timeout_evt_d;
      byte_cnt_q    <= byte_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
    end
  end

  assign owner       = owner_q;
  assign locked      = locked_q;
  assign timeout_evt = timeout_evt_q;
  assign byte_cnt    = byte_cnt_q;

endmodule
